// File: rtl/sobel_window_filter.sv
// rtl/sobel_window_filter.sv - streaming 3x3 Sobel edge detector over a sliding column window
// Three-stage pipeline: window load, |Gx|/|Gy|, sum and threshold compare.
module sobel_window_filter #(
   parameter int rows_width    = 3,
   parameter int im_width      = 320,
   parameter int color_width   = 12,
   parameter int im_width_bits = 9
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_enable,
   input  logic [rows_width*color_width-1:0] in_data,
   input  logic [color_width+3:0]            threshold,
   output logic                              out_ready,
   output logic [color_width+3:0]            out_mag,
   output logic                              out_edge
);

   localparam int CW = color_width;
   localparam int MW = color_width + 4;
   localparam int AW = color_width + 3;

   // index 0 = top row, 2 = bottom row
   logic [CW-1:0]            win_l [3];
   logic [CW-1:0]            win_m [3];
   logic [CW-1:0]            win_r [3];
   logic [im_width_bits-1:0] col;
   logic                     s0_valid, s0_border;

   logic                     s1_valid, s1_border;
   logic [AW-1:0]            s1_abs_gx, s1_abs_gy;

   logic [MW-1:0]            col_sum_l, col_sum_r, row_sum_t, row_sum_b;
   logic [MW-1:0]            gx, gy, abs_gx, abs_gy, mag_sum;

   function automatic logic [MW-1:0] ext(input logic [CW-1:0] p);
      return {4'b0000, p};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            win_l[i] <= '0;
            win_m[i] <= '0;
            win_r[i] <= '0;
         end
         col       <= '0;
         s0_valid  <= 1'b0;
         s0_border <= 1'b0;
      end else begin
         s0_valid <= in_enable;
         if (in_enable) begin
            for (int i = 0; i < 3; i++) begin
               win_l[i] <= win_m[i];
               win_m[i] <= win_r[i];
            end
            win_r[0]  <= in_data[CW-1:0];
            win_r[1]  <= in_data[2*CW-1:CW];
            win_r[2]  <= in_data[3*CW-1:2*CW];
            // the first two columns of a row have no complete left neighbourhood
            s0_border <= (col < im_width_bits'(2));
            if (col == im_width_bits'(im_width - 1))
               col <= '0;
            else
               col <= col + 1'b1;
         end
      end
   end

   always_comb begin
      col_sum_l = ext(win_l[0]) + (ext(win_l[1]) << 1) + ext(win_l[2]);
      col_sum_r = ext(win_r[0]) + (ext(win_r[1]) << 1) + ext(win_r[2]);
      row_sum_t = ext(win_l[0]) + (ext(win_m[0]) << 1) + ext(win_r[0]);
      row_sum_b = ext(win_l[2]) + (ext(win_m[2]) << 1) + ext(win_r[2]);
      gx        = col_sum_r - col_sum_l;
      gy        = row_sum_b - row_sum_t;
      abs_gx    = gx[MW-1] ? (~gx + 1'b1) : gx;
      abs_gy    = gy[MW-1] ? (~gy + 1'b1) : gy;
      mag_sum   = {1'b0, s1_abs_gx} + {1'b0, s1_abs_gy};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_border <= 1'b0;
         s1_abs_gx <= '0;
         s1_abs_gy <= '0;
         out_ready <= 1'b0;
         out_mag   <= '0;
         out_edge  <= 1'b0;
      end else begin
         s1_valid  <= s0_valid;
         s1_border <= s0_border;
         s1_abs_gx <= abs_gx[AW-1:0];
         s1_abs_gy <= abs_gy[AW-1:0];
         out_ready <= s1_valid;
         out_mag   <= (s1_valid && !s1_border) ? mag_sum : '0;
         out_edge  <= s1_valid && !s1_border && (mag_sum >= threshold);
      end
   end

endmodule

// File: doc/sobel_window_filter.md
# sobel_window_filter

Streaming 3×3 Sobel edge detector that sits directly downstream of the three-row line buffer in the plate-localisation pipeline. It consumes one vertical 3-pixel column per accepted beat and keeps a sliding 3×3 window. It produces, per input beat, an L1 gradient magnitude and a thresholded binary edge flag, which feed the edge-density/plate-candidate stage. No back-pressure: one output beat per input beat, fixed latency.

## Interface
- `rows_width`, 3: rows per input column; fixed at 3, other values unsupported.
- `im_width`, 320: pixels per image row.
- `color_width`, 12: bits per pixel, unsigned intensity.
- `im_width_bits`, 9: column counter width; must satisfy 2^im_width_bits ≥ im_width.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_enable`  in  1  column valid; sampled on rising edge of `clk`.
- `in_data`  in  rows_width*color_width  column: bits [cw-1:0] top (oldest) row, [2cw-1:cw] middle, [3cw-1:2cw] bottom (newest).
- `threshold`  in  color_width+4  edge threshold, sampled in final pipeline stage.
- `out_ready`  out  1  output beat valid, one cycle per beat.
- `out_mag`  out  color_width+4  |Gx|+|Gy|, zero when `out_ready`=0.
- `out_edge`  out  1  `out_mag` ≥ `threshold`, zero when `out_ready`=0.

## Operation
- Window: 3 columns × 3 rows of registers (L, M, R). On each edge with `in_enable`=1: L←M, M←R, R←`in_data`. Window holds when `in_enable`=0.
- Column counter `col`: increments on each accepted beat, wraps im_width-1 → 0. `col` tags the beat being loaded (value before increment).
- Border rule: beats with tag `col` ∈ {0,1} produce `out_mag`=0, `out_edge`=0, but still assert `out_ready`. Output count always equals input count.
- Gradient, indices pRC with R=row (0 top), C=column (0 = L):
  - Gx = (p02+2p12+p22) − (p00+2p10+p20)
  - Gy = (p20+2p21+p22) − (p00+2p01+p02)
- Arithmetic: Gx, Gy are signed, color_width+4 bits. |Gx|, |Gy| are unsigned, color_width+3 bits. Sum is color_width+4 bits, no overflow possible (max 6·(2^cw−1)). No saturation needed.
- Pipeline, valid bit and border flag travel with data:
  - S0: window load.
  - S1: register |Gx|, |Gy|.
  - S2: register sum, compare with `threshold`, register outputs.
- No stall path. Gaps in `in_enable` just insert bubbles.
- Reset: clears window, `col`, all pipeline valids and data; `out_ready`, `out_mag`, `out_edge` = 0. Reset mid-row discards in-flight beats; the next accepted beat is column 0.
- No frame/row counting: upstream presents only fully buffered columns.

## Timing
- `in_enable`=1 sampled at edge E0 → `out_ready`=1 after edge E2, for exactly one cycle. Latency 3 edges, including the load.
- Throughput: one beat per clock, sustained.
- `threshold` is applied to the beat in S1 at the edge entering S2. A change takes effect on the next registered output.
- `rst` high at any edge overrides `in_enable`. Outputs read 0 from the cycle after that edge. First valid output after reset is 3 edges after the first accepted beat.
- Simultaneous last column (`col`=im_width−1) and next beat: the wrap is seamless. The following beat is tagged 0 and bordered.

## Test plan
- Uniform field: all pixels 0x7FF, 320 beats → 320 `out_ready` pulses, all `out_mag`=0, `out_edge`=0.
- Vertical step: columns 0–4 = 0, columns ≥5 = 100, all rows equal, `threshold`=256 → beats tagged 5 and 6 give `out_mag`=400, `out_edge`=1. All other beats give 0.
- Horizontal step: top and middle rows 0, bottom row 4095 → non-border beats give `out_mag`=16380, `out_edge`=1 with `threshold`=16380, and `out_edge`=0 with `threshold`=16381.
- Max window: right column and bottom row 4095, others 0 → `out_mag`=24570. Then 320 beats with `in_enable` toggling every other cycle → output values identical to back-to-back run, each `out_ready` exactly 3 edges after its input.
- Reset mid-row: assert `rst` for 1 cycle after 100 beats of step data → outputs 0 next cycle, in-flight beats lost. Next two beats are bordered (`out_mag`=0) despite nonzero gradient content.
- Row wrap: 2×320 beats with a step straddling columns 319/0 → beats tagged 0 and 1 of row 2 output 0. Beat tagged 2 is computed normally.
